// File: rtl/minisrc_pkg.sv
// Shared MiniSRC control definitions: opcodes, sequencer states, ALU codes,
// datapath mux select codes and the decoded instruction-class record.
package minisrc_pkg;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_DIV  = 5'b01111;
   localparam logic [4:0] OP_MUL  = 5'b10000;
   localparam logic [4:0] OP_BR   = 5'b10010;
   localparam logic [4:0] OP_JR   = 5'b10011;
   localparam logic [4:0] OP_JAL  = 5'b10100;
   localparam logic [4:0] OP_HALT = 5'b11100;

   localparam logic [2:0] S_RESET  = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
   localparam logic [2:0] S_HALT   = 3'd6;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_OR  = 4'd2;
   localparam logic [3:0] ALU_AND = 4'd3;
   localparam logic [3:0] ALU_DIV = 4'd4;
   localparam logic [3:0] ALU_MUL = 4'd5;

   localparam logic [1:0] MC_RB   = 2'd0;
   localparam logic [1:0] MC_RC   = 2'd1;
   localparam logic [1:0] MC_LINK = 2'd2;
   localparam logic [1:0] MC_RA   = 2'd3;

   localparam logic [1:0] MY_RZ0  = 2'd0;
   localparam logic [1:0] MY_RZ1  = 2'd1;
   localparam logic [1:0] MY_MEM  = 2'd2;
   localparam logic [1:0] MY_PCT  = 2'd3;

   // Exactly one class flag is set for a defined opcode; none for nop/undefined.
   typedef struct packed {
      logic       rtype;
      logic       imm;
      logic       ld;
      logic       ldi;
      logic       st;
      logic       muldiv;
      logic       br;
      logic       jr;
      logic       jal;
      logic       halt;
      logic [3:0] alu;
   } dec_t;

endpackage

// File: rtl/cu_decoder.sv
// Combinational opcode decode into instruction-class flags and the EXEC ALU op.
module cu_decoder
   import minisrc_pkg::*;
(
   input  logic [4:0] opcode_i,
   output dec_t       dec_o
);

   always_comb begin
      dec_o = '0;
      case (opcode_i)
         OP_ADD:  begin dec_o.rtype  = 1'b1; dec_o.alu = ALU_ADD; end
         OP_SUB:  begin dec_o.rtype  = 1'b1; dec_o.alu = ALU_SUB; end
         OP_AND:  begin dec_o.rtype  = 1'b1; dec_o.alu = ALU_AND; end
         OP_OR:   begin dec_o.rtype  = 1'b1; dec_o.alu = ALU_OR;  end
         OP_ADDI: begin dec_o.imm    = 1'b1; dec_o.alu = ALU_ADD; end
         OP_ANDI: begin dec_o.imm    = 1'b1; dec_o.alu = ALU_AND; end
         OP_ORI:  begin dec_o.imm    = 1'b1; dec_o.alu = ALU_OR;  end
         OP_LD:   begin dec_o.ld     = 1'b1; dec_o.alu = ALU_ADD; end
         OP_LDI:  begin dec_o.ldi    = 1'b1; dec_o.alu = ALU_ADD; end
         OP_ST:   begin dec_o.st     = 1'b1; dec_o.alu = ALU_ADD; end
         OP_DIV:  begin dec_o.muldiv = 1'b1; dec_o.alu = ALU_DIV; end
         OP_MUL:  begin dec_o.muldiv = 1'b1; dec_o.alu = ALU_MUL; end
         OP_BR:   dec_o.br   = 1'b1;
         OP_JR:   dec_o.jr   = 1'b1;
         OP_JAL:  dec_o.jal  = 1'b1;
         OP_HALT: dec_o.halt = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// MiniSRC multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB with memory
// handshake stalls and a bus-error timeout into HALT.
module control_unit
   import minisrc_pkg::*;
#(
   parameter int WAIT_LIMIT = 16
) (
   input  logic       iClk,
   input  logic       nRst,
   input  logic [4:0] iOpcode,
   input  logic [1:0] iCond,
   input  logic       iZero,
   input  logic       iInstrValid,
   input  logic       iMemReady,
   output logic       ir_enable,
   output logic       ra_enable,
   output logic       rb_enable,
   output logic       rz0_enable,
   output logic       rz1_enable,
   output logic       rm_enable,
   output logic       ry_enable,
   output logic       rpc_enable,
   output logic       rpc_temp_enable,
   output logic       rf_write,
   output logic       mb_select,
   output logic       minc_select,
   output logic       mpc_select,
   output logic [1:0] mc_select,
   output logic [1:0] my_select,
   output logic [3:0] alu_control,
   output logic       instruction_mem_read,
   output logic       mem_read,
   output logic       mem_write,
   output logic [2:0] oState,
   output logic       oHalted,
   output logic       oBusErr
);

   localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] wait_q, wait_d;
   logic          berr_q, berr_d;
   dec_t          dec;
   logic          waiting, rdy, timeout, taken, skip_mem;

   cu_decoder u_dec (
      .opcode_i (iOpcode),
      .dec_o    (dec)
   );

   assign taken    = iCond[1] | (iCond[0] ? ~iZero : iZero);
   assign skip_mem = ~(dec.rtype | dec.imm | dec.ld | dec.ldi | dec.st | dec.muldiv | dec.jal);
   assign waiting  = (state_q == S_FETCH) || (state_q == S_MEM && (dec.ld || dec.st));
   assign rdy      = (state_q == S_FETCH) ? iInstrValid : iMemReady;
   // Counter holds ready-low cycles already spent; the LIMIT-th low cycle trips.
   assign timeout  = (WAIT_LIMIT != 0) && waiting && !rdy && (wait_q == CW'(WAIT_LIMIT - 1));

   always_comb begin
      state_d = state_q;
      berr_d  = berr_q;
      case (state_q)
         S_RESET:  state_d = S_FETCH;
         S_FETCH:  if (iInstrValid) state_d = S_DECODE;
         S_DECODE: state_d = dec.halt ? S_HALT : S_EXEC;
         S_EXEC:   state_d = skip_mem ? S_FETCH : S_MEM;
         S_MEM: begin
            if (dec.st)      begin if (iMemReady) state_d = S_FETCH; end
            else if (dec.ld) begin if (iMemReady) state_d = S_WB;    end
            else             state_d = S_WB;
         end
         S_WB:     state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_RESET;
      endcase
      if (timeout) begin
         state_d = S_HALT;
         berr_d  = 1'b1;
      end
      wait_d = wait_q;
      if (state_d != state_q)   wait_d = '0;
      else if (waiting && !rdy) wait_d = wait_q + CW'(1);
   end

   always_ff @(posedge iClk) begin
      if (!nRst) begin
         state_q <= S_RESET;
         wait_q  <= '0;
         berr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         berr_q  <= berr_d;
      end
   end

   always_comb begin
      ir_enable = 1'b0;  ra_enable = 1'b0;  rb_enable = 1'b0;
      rz0_enable = 1'b0; rz1_enable = 1'b0; rm_enable = 1'b0;
      ry_enable = 1'b0;  rpc_enable = 1'b0; rpc_temp_enable = 1'b0;
      rf_write = 1'b0;   mb_select = 1'b0;  minc_select = 1'b0;
      mpc_select = 1'b0; mc_select = MC_RB; my_select = MY_RZ0;
      alu_control = ALU_ADD;
      instruction_mem_read = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      if (nRst) begin
         case (state_q)
            S_FETCH: begin
               instruction_mem_read = 1'b1;
               if (iInstrValid) begin
                  ir_enable       = 1'b1;
                  rpc_temp_enable = 1'b1;
                  rpc_enable      = 1'b1;
                  mpc_select      = 1'b1;
               end
            end
            S_DECODE: begin
               ra_enable = 1'b1;
               rb_enable = 1'b1;
            end
            S_EXEC: begin
               alu_control = dec.alu;
               if (dec.rtype) rz0_enable = 1'b1;
               if (dec.imm || dec.ld || dec.ldi || dec.st) begin
                  mb_select  = 1'b1;
                  rz0_enable = 1'b1;
               end
               if (dec.st) rm_enable = 1'b1;
               if (dec.muldiv) begin
                  rz0_enable = 1'b1;
                  rz1_enable = 1'b1;
               end
               if (dec.br && taken) begin
                  rpc_enable  = 1'b1;
                  minc_select = 1'b1;
                  mpc_select  = 1'b1;
               end
               if (dec.jr || dec.jal) rpc_enable = 1'b1;
            end
            S_MEM: begin
               if (dec.ld) begin
                  mem_read = 1'b1;
                  if (iMemReady) begin
                     my_select = MY_MEM;
                     ry_enable = 1'b1;
                  end
               end else if (dec.st) begin
                  mem_write = 1'b1;
               end else if (dec.jal) begin
                  my_select = MY_PCT;
                  ry_enable = 1'b1;
               end else if (dec.rtype || dec.imm || dec.ldi || dec.muldiv) begin
                  ry_enable = 1'b1;
               end
            end
            S_WB: begin
               rf_write = 1'b1;
               if (dec.rtype || dec.muldiv) mc_select = MC_RC;
               else if (dec.jal)            mc_select = MC_LINK;
               else                         mc_select = MC_RA;
            end
            default: ;
         endcase
      end
   end

   assign oState  = nRst ? state_q : S_RESET;
   assign oHalted = nRst && (state_q == S_HALT);
   assign oBusErr = nRst && berr_q;

endmodule
